// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency SRAM-like port between the
// instruction-fetch and data requesters. One access outstanding at a time;
// data has priority; the completing owner is excluded from the arbitration
// in its own completion cycle so the other side can be issued back-to-back.
module mem_port_arbiter #(
  parameter int LATENCY = 1,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_rdy,
  output logic [31:0]   inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [3:0]    data_sel,
  input  logic [AW-1:0] data_addr,
  input  logic [31:0]   data_wdata,
  output logic          data_rdy,
  output logic [31:0]   data_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stall_fetch,
  output logic          stall_mem
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

  localparam logic [2:0] LAT = 3'(LATENCY);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic [2:0] cnt, cnt_nxt;
  // Remembers whether the outstanding data access is a store, so the
  // returned word is suppressed even if data_wr changes before completion.
  logic       store, store_nxt;

  logic done;
  logic arb_ok;
  logic data_cand;
  logic inst_cand;
  logic grant_data;
  logic grant_inst;

  // Arbitration: data over inst, owner excluded in its completion cycle.
  always_comb begin
    done       = (state == BUSY) && (cnt == LAT);
    arb_ok     = rst && ((state == IDLE) || done);
    data_cand  = data_req && !(done && (owner == OWN_DATA));
    inst_cand  = inst_req && !(done && (owner == OWN_INST));
    grant_data = arb_ok && data_cand;
    grant_inst = arb_ok && inst_cand && !data_cand;
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    store_nxt = store;
    if (grant_data || grant_inst) begin
      state_nxt = BUSY;
      cnt_nxt   = 3'd1;
      owner_nxt = grant_data ? OWN_DATA : OWN_INST;
      store_nxt = grant_data && data_wr;
    end else if (done) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      owner_nxt = OWN_NONE;
      store_nxt = 1'b0;
    end else if (state == BUSY) begin
      cnt_nxt = cnt + 3'd1;
    end
  end

  // Sequencer state register; reset discards any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_NONE;
      cnt   <= '0;
      store <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      store <= store_nxt;
    end
  end

  // Memory-side and requester-side outputs, all held at 0 during reset.
  always_comb begin
    mem_en      = grant_data || grant_inst;
    mem_addr    = '0;
    mem_wen     = '0;
    mem_wdata   = '0;
    if (grant_data) begin
      mem_addr  = data_addr;
      mem_wen   = data_wr ? data_sel : 4'b0000;
      mem_wdata = data_wdata;
    end else if (grant_inst) begin
      mem_addr  = inst_addr;
    end
    inst_rdy    = rst && done && (owner == OWN_INST);
    data_rdy    = rst && done && (owner == OWN_DATA);
    inst_rdata  = inst_rdy ? mem_rdata : '0;
    data_rdata  = (data_rdy && !store) ? mem_rdata : '0;
    stall_fetch = rst && inst_req && !inst_rdy;
    stall_mem   = rst && data_req && !data_rdy;
  end

endmodule
